// File: rtl/calc_hist.sv
// calc_hist: accumulator calculator with debounced one-shot buttons and an
// undoable circular history stack.
//   clk, rst         : system clock, asynchronous active-high reset
//   btnl/btnc/btnr   : operation select {btnl,btnc,btnr}, level-sampled
//   btnd / btnu      : execute / clear buttons (debounced, one-shot)
//   undo             : undo button (debounced, one-shot)
//   sw               : two's complement operand
//   led              : accumulator value
//   zero             : accumulator == 0
//   ovf              : signed overflow of the last executed ADD/SUB
//   hist_cnt         : number of valid history entries
module calc_hist #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       btnl,
  input  logic                       btnc,
  input  logic                       btnr,
  input  logic                       btnd,
  input  logic                       btnu,
  input  logic                       undo,
  input  logic [WIDTH-1:0]           sw,
  output logic [WIDTH-1:0]           led,
  output logic                       zero,
  output logic                       ovf,
  output logic [$clog2(DEPTH+1)-1:0] hist_cnt
);

  localparam int unsigned CW = $clog2(DEBOUNCE + 1);
  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned HW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] DB_MAX  = CW'(DEBOUNCE);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE - 1);
  localparam logic [PW-1:0] P_LAST  = PW'(DEPTH - 1);
  localparam logic [HW-1:0] H_FULL  = HW'(DEPTH);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRA = 3'b110,
    OP_SLT = 3'b111
  } op_t;

  // Button lanes: 0 = undo, 1 = execute, 2 = clear
  logic [2:0]    raw, s1, s2, pulse;
  logic [CW-1:0] cnt [3];

  assign raw = {btnu, btnd, undo};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= '0;
      s2    <= '0;
      pulse <= '0;
      for (int unsigned i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int unsigned i = 0; i < 3; i++) begin
        if (!s2[i])
          cnt[i] <= '0;
        else if (cnt[i] != DB_MAX)
          cnt[i] <= cnt[i] + 1'b1;
        // fires only on the step into DB_MAX; saturation keeps it one-shot
        pulse[i] <= s2[i] && (cnt[i] == DB_LAST);
      end
    end
  end

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr, wptr_next, wptr_prev;

  logic             do_clr, do_exe, do_undo, push;
  op_t              op;
  logic [WIDTH-1:0] sum, diff, res;
  logic [SW-1:0]    sh;
  logic             alu_ov;

  assign do_clr  = pulse[2];
  assign do_exe  = pulse[1] & ~pulse[2];
  assign do_undo = pulse[0] & ~pulse[1] & ~pulse[2];
  assign push    = do_clr | do_exe;

  assign wptr_next = (wptr == P_LAST) ? '0 : wptr + 1'b1;
  assign wptr_prev = (wptr == '0) ? P_LAST : wptr - 1'b1;

  assign op   = op_t'({btnl, btnc, btnr});
  assign sum  = acc + sw;
  assign diff = acc - sw;
  assign sh   = sw[SW-1:0];

  always_comb begin
    res    = '0;
    alu_ov = 1'b0;
    unique case (op)
      OP_ADD: begin
        res    = sum;
        alu_ov = (acc[WIDTH-1] == sw[WIDTH-1]) && (sum[WIDTH-1] != acc[WIDTH-1]);
      end
      OP_SUB: begin
        res    = diff;
        alu_ov = (acc[WIDTH-1] != sw[WIDTH-1]) && (diff[WIDTH-1] != acc[WIDTH-1]);
      end
      OP_AND: res = acc & sw;
      OP_OR:  res = acc | sw;
      OP_XOR: res = acc ^ sw;
      OP_SLL: res = acc << sh;
      OP_SRA: res = $signed(acc) >>> sh;
      OP_SLT: res[0] = $signed(acc) < $signed(sw);
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= acc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      ovf      <= 1'b0;
      hist_cnt <= '0;
      wptr     <= '0;
    end else if (do_clr) begin
      acc  <= '0;
      ovf  <= 1'b0;
      wptr <= wptr_next;
      if (hist_cnt != H_FULL) hist_cnt <= hist_cnt + 1'b1;
    end else if (do_exe) begin
      acc  <= res;
      ovf  <= alu_ov;
      wptr <= wptr_next;
      if (hist_cnt != H_FULL) hist_cnt <= hist_cnt + 1'b1;
    end else if (do_undo) begin
      ovf <= 1'b0;
      if (hist_cnt != '0) begin
        acc      <= mem[wptr_prev];
        wptr     <= wptr_prev;
        hist_cnt <= hist_cnt - 1'b1;
      end
    end
  end

  assign led  = acc;
  assign zero = (acc == '0);

endmodule

// File: tb/tb_calc_hist.sv
module tb_calc_hist;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int DB = 4;
  localparam int HW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          btnl, btnc, btnr, btnd, btnu, undo;
  logic [W-1:0]  sw;
  logic [W-1:0]  led;
  logic          zero, ovf;
  logic [HW-1:0] hist_cnt;

  always #5 clk = ~clk;

  calc_hist #(.WIDTH(W), .DEPTH(D), .DEBOUNCE(DB)) dut (
    .clk(clk), .rst(rst),
    .btnl(btnl), .btnc(btnc), .btnr(btnr),
    .btnd(btnd), .btnu(btnu), .undo(undo),
    .sw(sw), .led(led), .zero(zero), .ovf(ovf), .hist_cnt(hist_cnt)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit cmp_en      = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A press is accepted once the raw level has been sampled high on DB
  // consecutive edges; its effect lands three edges after that sample.
  logic [W-1:0] m_acc;
  bit           m_ovf;
  logic [W-1:0] m_stack [$];
  int           run [3];
  bit   [2:0]   rbits, det, act, d0, d1, d2;
  logic [W-1:0] m_res;
  bit           m_v;

  function automatic void alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                              output logic [W-1:0] r, output bit v);
    longint sa, sb, full, lo, hi;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lo = -(longint'(1) << (W - 1));
    hi = (longint'(1) << (W - 1)) - 1;
    sh = int'(b % W);
    v  = 1'b0;
    case (op)
      3'd0: begin full = sa + sb; v = (full > hi) || (full < lo); r = W'(full); end
      3'd1: begin full = sa - sb; v = (full > hi) || (full < lo); r = W'(full); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << sh;
      3'd6: begin full = sa >>> sh; r = W'(full); end
      default: r = (sa < sb) ? W'(1) : W'(0);
    endcase
  endfunction

  task automatic m_push(input logic [W-1:0] v);
    m_stack.push_back(v);
    if (m_stack.size() > D) void'(m_stack.pop_front());
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_acc = '0;
      m_ovf = 1'b0;
      m_stack.delete();
      for (int i = 0; i < 3; i++) run[i] = 0;
      d0 = '0; d1 = '0; d2 = '0;
    end else begin
      rbits = {btnu, btnd, undo};
      for (int i = 0; i < 3; i++) begin
        if (rbits[i]) run[i] = (run[i] > DB) ? run[i] : run[i] + 1;
        else          run[i] = 0;
        det[i] = rbits[i] && (run[i] == DB);
      end
      act = d2; d2 = d1; d1 = d0; d0 = det;
      if (act[2]) begin
        m_push(m_acc);
        m_acc = '0;
        m_ovf = 1'b0;
      end else if (act[1]) begin
        alu({btnl, btnc, btnr}, m_acc, sw, m_res, m_v);
        m_push(m_acc);
        m_acc = m_res;
        m_ovf = m_v;
      end else if (act[0]) begin
        m_ovf = 1'b0;
        if (m_stack.size() > 0) m_acc = m_stack.pop_back();
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("led",      32'(led),      32'(m_acc));
      chk("zero",     32'(zero),     32'(m_acc == '0));
      chk("ovf",      32'(ovf),      32'(m_ovf));
      chk("hist_cnt", 32'(hist_cnt), 32'(m_stack.size()));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_btn(input int which, input logic v);
    case (which)
      0:       undo = v;
      1:       btnd = v;
      default: btnu = v;
    endcase
  endtask

  // which: 0 undo, 1 execute, 2 clear
  task automatic op_press(input logic [2:0] op, input logic [W-1:0] v, input int which);
    @(negedge clk);
    {btnl, btnc, btnr} = op;
    sw = v;
    set_btn(which, 1'b1);
    repeat (DB + 2) @(negedge clk);
    set_btn(which, 1'b0);
    repeat (6) @(negedge clk);
  endtask

  task automatic expect_st(input string nm, input logic [W-1:0] l, input int h, input bit o);
    chk({nm, ".led"},  32'(led),      32'(l));
    chk({nm, ".hist"}, 32'(hist_cnt), 32'(h));
    chk({nm, ".ovf"},  32'(ovf),      32'(o));
  endtask

  int sel, hold, gap;

  initial begin
    rst = 1'b1;
    {btnl, btnc, btnr} = 3'b000;
    btnd = 1'b0; btnu = 1'b0; undo = 1'b0;
    sw = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst.led",  32'(led),      32'h0);
    chk("rst.zero", 32'(zero),     32'h1);
    chk("rst.ovf",  32'(ovf),      32'h0);
    chk("rst.hist", 32'(hist_cnt), 32'h0);
    cmp_en = 1'b1;

    // Latency: press sampled at edge 1, led updates at edge 7
    @(negedge clk);
    sw = 16'd5; {btnl, btnc, btnr} = 3'b000; btnd = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("lat.before", 32'(led), 32'h0);
    @(posedge clk);
    #1 chk("lat.at7", 32'(led), 32'h5);
    chk("lat.hist", 32'(hist_cnt), 32'h1);
    chk("lat.zero", 32'(zero), 32'h0);
    repeat (3) @(posedge clk);
    #1 chk("lat.held", 32'(led), 32'h5);
    @(negedge clk) btnd = 1'b0;
    repeat (6) @(negedge clk);
    expect_st("lat.after", 16'h0005, 1, 1'b0);

    // Overflow and flag behaviour
    op_press(3'b000, 16'h7FFA, 1); expect_st("add7fff", 16'h7FFF, 2, 1'b0);
    op_press(3'b000, 16'h0001, 1); expect_st("addovf",  16'h8000, 3, 1'b1);
    op_press(3'b100, 16'h0000, 1); expect_st("xor0",    16'h8000, 4, 1'b0);
    op_press(3'b111, 16'h0001, 1); expect_st("slt",     16'h0001, 5, 1'b0);

    // Clear is undoable
    op_press(3'b000, 16'h0000, 2); expect_st("clr1", 16'h0000, 6, 1'b0);
    op_press(3'b000, 16'h1234, 1); expect_st("set1234", 16'h1234, 7, 1'b0);
    op_press(3'b000, 16'h0000, 2); expect_st("clr2", 16'h0000, 8, 1'b0);
    chk("clr2.zero", 32'(zero), 32'h1);
    op_press(3'b000, 16'h0000, 0); expect_st("undoclr", 16'h1234, 7, 1'b0);

    // History wrap
    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 10; k++) op_press(3'b000, 16'h0001, 1);
    expect_st("wrap", 16'd10, 8, 1'b0);
    for (int k = 0; k < 8; k++) begin
      op_press(3'b000, 16'h0000, 0);
      expect_st("undo", W'(9 - k), 7 - k, 1'b0);
    end
    op_press(3'b000, 16'h0000, 0);
    expect_st("undo.empty", 16'd2, 0, 1'b0);

    // Clear beats execute on the same edge
    @(negedge clk);
    sw = 16'd5; {btnl, btnc, btnr} = 3'b000;
    btnu = 1'b1; btnd = 1'b1;
    repeat (DB + 2) @(negedge clk);
    btnu = 1'b0; btnd = 1'b0;
    repeat (6) @(negedge clk);
    expect_st("prio", 16'd0, 1, 1'b0);

    // Short glitch is ignored
    @(negedge clk); btnd = 1'b1;
    repeat (3) @(negedge clk); btnd = 1'b0;
    repeat (10) @(negedge clk);
    expect_st("glitch", 16'd0, 1, 1'b0);

    // Reset while a press is held
    op_press(3'b000, 16'd7, 1); expect_st("acc7", 16'd7, 2, 1'b0);
    @(negedge clk); sw = 16'd3; btnd = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("arst.led",  32'(led),  32'h0);
    chk("arst.zero", 32'(zero), 32'h1);
    chk("arst.hist", 32'(hist_cnt), 32'h0);
    @(negedge clk) rst = 1'b0;
    repeat (DB + 3) @(posedge clk);
    #1 chk("arst.exec", 32'(led), 32'h3);
    repeat (8) @(negedge clk);
    expect_st("arst.once", 16'd3, 1, 1'b0);
    btnd = 1'b0;
    repeat (6) @(negedge clk);

    // Randomised traffic
    for (int it = 0; it < 300; it++) begin
      @(negedge clk);
      {btnl, btnc, btnr} = 3'($urandom);
      sw = W'($urandom);
      sel = $urandom_range(0, 9);
      if (sel < 6)      btnd = 1'b1;
      else if (sel < 8) btnu = 1'b1;
      else              undo = 1'b1;
      if ($urandom_range(0, 7) == 0) set_btn($urandom_range(0, 2), 1'b1);
      hold = $urandom_range(1, 8);
      repeat (hold) @(negedge clk);
      btnd = 1'b0; btnu = 1'b0; undo = 1'b0;
      gap = $urandom_range(0, 5);
      repeat (gap) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
